hll_register_update: RTL
========================

# hll_register_update

HyperLogLog register file and update stage; sits directly downstream of the leading-zero counter. Each accepted sample carries a bucket index and that bucket's leading-zero count. The block forms rank = lzc + 1 and keeps the per-bucket maximum rank. It also maintains two running estimator statistics incrementally: the number of zero-valued buckets and the harmonic sum Σ2^-M[j] in fixed point. A downstream estimator reads these directly, with no sweep of the register file.

## Interface

Parameters:
- P, 4: index bits; bucket count M = 2^P.
- LZC_W, 5: width of incoming leading-zero count.
- RMAX, 2^LZC_W (derived): maximum rank, 32 at defaults.
- RANK_W, LZC_W+1 (derived): stored rank width.
- SUM_W, RMAX+P+1 (derived): harmonic-sum width, 37 at defaults. LSB weight is 2^-RMAX.

Ports:
- clk, in, 1: sole clock; all state updates on rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- in_valid, in, 1: sample present.
- in_ready, out, 1: block accepts a sample on any edge where in_valid && in_ready.
- in_index, in, P: bucket index.
- in_lzc, in, LZC_W: leading-zero count from the upstream counter.
- clear_req, in, 1: request to zero all buckets.
- busy, out, 1: high while a clear sweep is in progress.
- rd_index, in, P: debug/readout bucket select.
- rd_rank, out, RANK_W: registered M[rd_index].
- zero_count, out, P+1: number of buckets holding 0.
- harmonic_sum, out, SUM_W: Σ_j 2^(RMAX−M[j]), in LSB units.

## Operation

- State: RUN, CLEAR. Reset enters RUN.
- Reset values:
  - M[j]=0 for all j.
  - zero_count=M.
  - harmonic_sum = M<<RMAX (e.g. 2^36).
  - rd_rank=0, busy=0.
  - Stage-1 valid=0.
- in_ready = (state==RUN) && !clear_req. The ready path is combinational from clear_req only.
- Stage 1, on accept: latch index and rank = in_lzc+1, evaluated in RANK_W bits with range 1..RMAX. Set s1_valid.
- Stage 2, when s1_valid: read old = M[idx].
  - If rank > old: write M[idx]=rank and set harmonic_sum += (1<<(RMAX−rank)) − (1<<(RMAX−old)).
  - If in addition old==0: zero_count −= 1.
  - If rank ≤ old: no change to the register or the stats.
- Stage 2 reads the register file in the same cycle it writes. Back-to-back samples to the same index therefore see the prior write, and no stall or forward is needed.
- RUN→CLEAR: taken at the edge where clear_req=1 in RUN.
  - A stage-1 sample in flight at that edge still completes its write at that edge.
  - s1_valid is then cleared; no sample is accepted on that edge.
- CLEAR: sweep pointer k = 0..M−1, one bucket per cycle.
  - Set M[k]=0.
  - If old ≠ 0: harmonic_sum += (1<<RMAX) − (1<<(RMAX−old)) and zero_count += 1.
  - After k=M−1, return to RUN.
  - busy=1 throughout CLEAR.
  - clear_req during CLEAR is ignored and does not restart the sweep.
- Final-state invariant after a clear: all stats equal their reset values.
- Readout: rd_rank <= M[rd_index] every cycle, including during CLEAR, where it shows the in-progress values.
- Arithmetic is exact. harmonic_sum never over- or underflows, because 0 ≤ sum ≤ M·2^RMAX by construction. The maximum rank RMAX contributes term 1 (2^0).
- Asserting rst_n low mid-sweep or mid-update immediately forces all reset values, asynchronously.

## Timing

- Accept at edge N. Register and stats reflect the sample at edge N+1, so they are visible in cycle N+1.
- Throughput is 1 sample/cycle in RUN.
- rd_rank has 1-cycle latency from rd_index and from any write.
- Clear: clear_req sampled at edge C.
  - busy=1 from cycle C+1 through the cycle the last bucket clears, M cycles total.
  - Sweep writes occur at edges C+1..C+M.
  - in_ready is low during cycles C..C+M and returns high in cycle C+M+1.
- zero_count and harmonic_sum are registered outputs; they change only on the edges listed above.

## Test plan

- Reset: release rst_n, then hold idle for 3 cycles. Expect zero_count=16, harmonic_sum=2^36, rd_rank=0 for all indices, and in_ready=1.
- Single update: index 3, lzc 4. Expect M[3]=5 one cycle after accept, zero_count=15, harmonic_sum=15·2^32+2^27.
- Max-only rule: after the single update, send index 3 with lzc 2, then index 3 with lzc 31 back-to-back. Expect M[3] stays 5, then becomes 32. Expect harmonic_sum=15·2^32+1 and zero_count=15.
- Streaming: send 16 consecutive samples, index j with lzc j mod 8, with in_valid held high. Expect in_ready stays high. Expect every bucket to end at the rank (j mod 8)+1, giving zero_count=0. Expect harmonic_sum equal to the model sum.
- Clear with traffic: during the streaming test, pulse clear_req while in_valid=1.
  - Expect the in-flight sample to be written, then in_ready low for 17 cycles and busy high for 16.
  - Expect a new clear_req pulse mid-sweep not to extend the sweep.
  - Expect the stats to end at 16 and 2^36.
- Async reset mid-sweep: pull rst_n low at sweep index 7. Expect the reset values immediately, without waiting for clk, and RUN after release.

Source files
------------

// File: rtl/hll_register_update.sv
// HyperLogLog register file with incremental zero-count and harmonic-sum stats.
// Two-stage update (latch, then read-modify-write) plus a one-bucket-per-cycle clear sweep.
module hll_register_update #(
  parameter int P     = 4,
  parameter int LZC_W = 5,
  localparam int M      = 1 << P,
  localparam int RMAX   = 1 << LZC_W,
  localparam int RANK_W = LZC_W + 1,
  localparam int SUM_W  = RMAX + P + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [P-1:0]      in_index,
  input  logic [LZC_W-1:0]  in_lzc,
  input  logic              clear_req,
  output logic              busy,
  input  logic [P-1:0]      rd_index,
  output logic [RANK_W-1:0] rd_rank,
  output logic [P:0]        zero_count,
  output logic [SUM_W-1:0]  harmonic_sum
);

  typedef enum logic {RUN, CLEAR} state_t;

  state_t              state_q, state_d;
  logic [P-1:0]        k_q;
  logic                s1_valid;
  logic [P-1:0]        s1_idx;
  logic [RANK_W-1:0]   s1_rank;
  logic [RANK_W-1:0]   mem [M];
  logic [P:0]          zc_d;
  logic [SUM_W-1:0]    hs_d;
  logic [RANK_W-1:0]   old;
  logic [RANK_W-1:0]   sw_old;
  logic                accept;
  logic                upd;
  logic                sw_nz;

  function automatic logic [SUM_W-1:0] pow2(input logic [RANK_W-1:0] e);
    pow2 = SUM_W'(1) << e;
  endfunction

  assign in_ready = (state_q == RUN) && !clear_req;
  assign busy     = (state_q == CLEAR);
  assign accept   = in_valid && in_ready;

  assign old    = mem[s1_idx];
  assign sw_old = mem[k_q];
  assign upd    = s1_valid && (s1_rank > old);
  assign sw_nz  = busy && (sw_old != '0);

  // Intermediate wrap is harmless: the final sum is always in range.
  always_comb begin
    zc_d = zero_count;
    hs_d = harmonic_sum;
    if (upd) begin
      hs_d = harmonic_sum
           + pow2(RANK_W'(RMAX) - s1_rank)
           - pow2(RANK_W'(RMAX) - old);
      if (old == '0) zc_d = zero_count - 1'b1;
    end else if (sw_nz) begin
      hs_d = harmonic_sum
           + pow2(RANK_W'(RMAX))
           - pow2(RANK_W'(RMAX) - sw_old);
      zc_d = zero_count + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:   if (clear_req) state_d = CLEAR;
      CLEAR: if (k_q == P'(M - 1)) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      k_q          <= '0;
      s1_valid     <= 1'b0;
      s1_idx       <= '0;
      s1_rank      <= '0;
      zero_count   <= (P+1)'(M);
      harmonic_sum <= SUM_W'(M) << RMAX;
      rd_rank      <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= busy ? k_q + 1'b1 : '0;
      s1_valid     <= accept;
      if (accept) begin
        s1_idx  <= in_index;
        s1_rank <= {1'b0, in_lzc} + RANK_W'(1);
      end
      zero_count   <= zc_d;
      harmonic_sum <= hs_d;
      rd_rank      <= mem[rd_index];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < M; j++) mem[j] <= '0;
    end else if (upd) begin
      mem[s1_idx] <= s1_rank;
    end else if (busy) begin
      mem[k_q] <= '0;
    end
  end

endmodule
